// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the dcache (p0) and the PTW (p1).
// Optional WAIT-state watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module main_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int WDATA_W        = 32,
    parameter int LINE_W         = 512,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  p0_addr,
    input  logic [ADDR_W-1:0]  p1_addr,
    input  logic [WDATA_W-1:0] p0_wdata,
    input  logic [WDATA_W-1:0] p1_wdata,
    input  logic               p0_read_req,
    input  logic               p1_read_req,
    input  logic               p0_write_req,
    input  logic               p1_write_req,
    output logic [LINE_W-1:0]  p0_rdata,
    output logic [LINE_W-1:0]  p1_rdata,
    output logic               p0_ready,
    output logic               p1_ready,
    output logic               p0_err,
    output logic               p1_err,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_wdata,
    output logic               mem_read_req,
    output logic               mem_write_req,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         pend_q, pend_d;
    logic [1:0]         op_q, op_d;
    logic [ADDR_W-1:0]  addr_q [2];
    logic [ADDR_W-1:0]  addr_d [2];
    logic [WDATA_W-1:0] wdata_q [2];
    logic [WDATA_W-1:0] wdata_d [2];
    logic               gnt_q, gnt_d;
    logic               last_q, last_d;
    logic [LINE_W-1:0]  rdata0_q, rdata0_d;
    logic [LINE_W-1:0]  rdata1_q, rdata1_d;

    logic [ADDR_W-1:0]  in_addr [2];
    logic [WDATA_W-1:0] in_wdata [2];
    logic [1:0]         req;
    logic [1:0]         wr_req;
    logic [1:0]         resp_clr;
    logic               timeout;

    assign in_addr[0]  = p0_addr;
    assign in_addr[1]  = p1_addr;
    assign in_wdata[0] = p0_wdata;
    assign in_wdata[1] = p1_wdata;
    assign wr_req      = {p1_write_req, p0_write_req};
    assign req         = {p1_read_req, p0_read_req} | wr_req;
    assign resp_clr[0] = (state_q == S_RESP) && !gnt_q;
    assign resp_clr[1] = (state_q == S_RESP) && gnt_q;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout = (state_q == S_WAIT) && !mem_ready
                  && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT && !mem_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign p0_err = resp_clr[0] && err_q;
    assign p1_err = resp_clr[1] && err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
    assign p0_err             = 1'b0;
    assign p1_err             = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (|pend_q) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (mem_ready || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and slot registers only
    always_comb begin
        mem_read_req  = (state_q == S_ISSUE) && !op_q[gnt_q];
        mem_write_req = (state_q == S_ISSUE) && op_q[gnt_q];
        mem_addr      = (state_q == S_ISSUE) ? addr_q[gnt_q] : '0;
        mem_wdata     = (state_q == S_ISSUE) ? wdata_q[gnt_q] : '0;
        p0_ready      = resp_clr[0];
        p1_ready      = resp_clr[1];
        p0_rdata      = rdata0_q;
        p1_rdata      = rdata1_q;
    end

    // Slot capture: a new pulse may refill a slot in its own RESP cycle
    always_comb begin
        pend_d  = pend_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        for (int i = 0; i < 2; i++) begin
            if (resp_clr[i]) begin
                pend_d[i] = 1'b0;
            end
            if (req[i] && (!pend_q[i] || resp_clr[i])) begin
                pend_d[i]  = 1'b1;
                op_d[i]    = wr_req[i];
                addr_d[i]  = in_addr[i];
                wdata_d[i] = in_wdata[i];
            end
        end
    end

    always_comb begin
        gnt_d    = gnt_q;
        last_d   = last_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (state_q == S_IDLE && |pend_q) begin
            gnt_d = (pend_q[0] && pend_q[1]) ? !last_q : pend_q[1];
        end
        if (state_q == S_RESP) begin
            last_d = gnt_q;
        end
        if (state_q == S_WAIT && mem_ready && !op_q[gnt_q]) begin
            if (gnt_q) rdata1_d = mem_rdata;
            else       rdata0_d = mem_rdata;
        end else if (timeout) begin
            if (gnt_q) rdata1_d = '0;
            else       rdata0_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            op_q       <= '0;
            addr_q[0]  <= '0;
            addr_q[1]  <= '0;
            wdata_q[0] <= '0;
            wdata_q[1] <= '0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            pend_q   <= pend_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter with a small latency-driven memory responder.
// Timeout vectors apply when MEM_ARB_TIMEOUT_EN is defined.
module tb_main_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic         p0_read_req, p1_read_req, p0_write_req, p1_write_req;
    logic [511:0] p0_rdata, p1_rdata;
    logic         p0_ready, p1_ready, p0_err, p1_err;
    logic [31:0]  mem_addr, mem_wdata;
    logic         mem_read_req, mem_write_req;
    logic [511:0] mem_rdata;
    logic         mem_ready;

    main_mem_arbiter #(
        .ADDR_W(32), .WDATA_W(32), .LINE_W(512), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_read_req(p0_read_req), .p1_read_req(p1_read_req),
        .p0_write_req(p0_write_req), .p1_write_req(p1_write_req),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_ready(p0_ready), .p1_ready(p1_ready),
        .p0_err(p0_err), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int cd = 0;
    int lat = 3;
    bit mem_auto = 1'b1;
    logic [511:0] mem_line;
    int n_mrd, n_mwr, n_p0, n_p1, p0_cyc, p1_cyc;
    logic [31:0] iss_addr[$];
    logic [31:0] iss_wd[$];
    int iss_cyc[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample 1 ns after the edge, then drive this cycle's inputs
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        p0_read_req = 0; p1_read_req = 0;
        p0_write_req = 0; p1_write_req = 0;
        mem_ready = 0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mem_ready = 1;
                mem_rdata = mem_line;
            end
        end
        if (mem_read_req || mem_write_req) begin
            if (mem_read_req) n_mrd++;
            if (mem_write_req) n_mwr++;
            iss_addr.push_back(mem_addr);
            iss_wd.push_back(mem_wdata);
            iss_cyc.push_back(cyc);
            if (mem_auto) cd = lat;
        end
        if (p0_ready) begin n_p0++; p0_cyc = cyc; end
        if (p1_ready) begin n_p1++; p1_cyc = cyc; end
    endtask

    task automatic clr();
        n_mrd = 0; n_mwr = 0; n_p0 = 0; n_p1 = 0;
        p0_cyc = -1; p1_cyc = -1;
        iss_addr.delete(); iss_wd.delete(); iss_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        cd = 0;
    endtask

    task automatic wait_rdy(input int port, input int maxc, input string tag);
        int k;
        k = 0;
        while (((port == 0) ? n_p0 : n_p1) < 1 && k < maxc) begin
            step();
            k++;
        end
        if (((port == 0) ? n_p0 : n_p1) < 1) chk(tag, 0, 1);
    endtask

    function automatic logic [31:0] qa(input int i);
        return (iss_addr.size() > i) ? iss_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int qc(input int i);
        return (iss_cyc.size() > i) ? iss_cyc[i] : -100;
    endfunction

    localparam logic [511:0] LA5 = {16{32'hA5A5_A5A5}};
    localparam logic [511:0] L12 = {16{32'h1111_2222}};
    localparam logic [511:0] L3C = {64{8'h3C}};
    localparam logic [511:0] L77 = {16{32'h7777_0001}};

    int t0;

    initial begin
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        p0_read_req = 0; p1_read_req = 0; p0_write_req = 0; p1_write_req = 0;
        mem_rdata = 0; mem_ready = 0; mem_line = 0; rst = 1;

        do_reset();
        chk("rst_mem_rd", mem_read_req, 0);
        chk("rst_mem_wr", mem_write_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_p0_ready", p0_ready, 0);
        chk("rst_p1_ready", p1_ready, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p0_err", p0_err, 0);

        // Single port-0 read, memory answers 3 cycles after the request
        clr(); lat = 3; mem_line = LA5;
        step();
        p0_read_req = 1; p0_addr = 32'h0000_1040; t0 = cyc;
        step();
        chk("rd_t1_no_req", mem_read_req, 0);
        step();
        chk("rd_t2_req", mem_read_req, 1);
        chk("rd_t2_addr", mem_addr, 32'h0000_1040);
        step(); step(); step();
        chk("rd_mem_ready", mem_ready, 1);
        step();
        chk("rd_p0_ready", p0_ready, 1);
        chk("rd_p0_rdata", p0_rdata, LA5);
        chk("rd_p0_err", p0_err, 0);
        chk("rd_p1_ready", p1_ready, 0);
        chk("rd_ready_cyc", p0_cyc - t0, 6);
        step();
        chk("rd_ready_pulse", p0_ready, 0);
        chk("rd_addr_idle", mem_addr, 0);

        // Simultaneous reads right after reset: port 0 first, twice
        do_reset(); clr(); mem_line = L12;
        step();
        p0_read_req = 1; p0_addr = 32'h100;
        p1_read_req = 1; p1_addr = 32'h200;
        wait_rdy(1, 60, "tie1_timeout");
        chk("tie1_first", qa(0), 32'h100);
        chk("tie1_second", qa(1), 32'h200);
        chk("tie1_gap", qc(1) - p0_cyc, 2);
        chk("tie1_p1_rdata", p1_rdata, L12);
        step(); step();
        clr();
        step();
        p0_read_req = 1; p0_addr = 32'h104;
        p1_read_req = 1; p1_addr = 32'h204;
        wait_rdy(1, 60, "tie2_timeout");
        chk("tie2_first", qa(0), 32'h104);
        chk("tie2_second", qa(1), 32'h204);
        chk("tie2_p0_cnt", n_p0, 1);
        step(); step();

        // Port-1 write leaves p1_rdata alone
        clr(); mem_line = L3C;
        step();
        p1_write_req = 1; p1_addr = 32'h0000_2000; p1_wdata = 32'hDEAD_BEEF;
        wait_rdy(1, 40, "wr_timeout");
        chk("wr_cnt", n_mwr, 1);
        chk("wr_rd_cnt", n_mrd, 0);
        chk("wr_addr", qa(0), 32'h0000_2000);
        chk("wr_wdata", (iss_wd.size() > 0) ? iss_wd[0] : 32'h0, 32'hDEAD_BEEF);
        chk("wr_p1_rdata", p1_rdata, L12);
        step(); step();

        // Second pulse while pending is dropped
        clr(); mem_line = L77;
        step();
        p0_read_req = 1; p0_addr = 32'h500;
        step();
        p0_read_req = 1; p0_addr = 32'h600;
        repeat (25) step();
        chk("drop_memrd", n_mrd, 1);
        chk("drop_p0rdy", n_p0, 1);
        chk("drop_addr", qa(0), 32'h500);

        // Reset while in WAIT; a late mem_ready must be ignored
        clr(); lat = 3;
        step();
        p0_read_req = 1; p0_addr = 32'h300;
        step(); step(); step();
        rst = 1;
        step();
        rst = 0;
        repeat (15) step();
        chk("rstw_p0rdy", n_p0, 0);
        chk("rstw_p1rdy", n_p1, 0);
        chk("rstw_memreq", n_mrd + n_mwr, 1);
        chk("rstw_idle_addr", mem_addr, 0);

        // Memory never answers
        clr(); mem_auto = 0; cd = 0;
        step();
        p0_read_req = 1; p0_addr = 32'h400; t0 = cyc;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_rdy(0, 40, "to_wait");
        chk("to_cyc", p0_cyc - t0, 11);
        chk("to_err", p0_err, 1);
        chk("to_rdata", p0_rdata, 0);
        step();
        chk("to_err_pulse", p0_err, 0);
`else
        repeat (40) step();
        chk("nto_stuck", n_p0, 0);
        mem_ready = 1; mem_rdata = L3C;
        step();
        chk("nto_ready", p0_ready, 1);
        chk("nto_rdata", p0_rdata, L3C);
        chk("nto_err", p0_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Two-port arbiter that shares the single main-memory port between the data cache controller (port 0) and the MMU page-table walker (port 1). Both requesters use the same one-cycle-pulse protocol: a `read_req`/`write_req` pulse with address and write data, then a wait for `ready`. The arbiter latches each pulse into a per-port pending slot and serialises the slots onto memory in round-robin order. It returns the 512-bit line and a one-cycle `ready` pulse to the owning requester.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `WDATA_W`, 32, write-data width
- `LINE_W`, 512, read line width
- `TIMEOUT_CYCLES`, 256, WAIT-state limit; used only with `MEM_ARB_TIMEOUT_EN`

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `p0_addr`, `p1_addr`  in  ADDR_W  request address; sampled only in the pulse cycle
- `p0_wdata`, `p1_wdata`  in  WDATA_W  write data; sampled only in the pulse cycle
- `p0_read_req`, `p1_read_req`  in  1  one-cycle read request pulse
- `p0_write_req`, `p1_write_req`  in  1  one-cycle write request pulse
- `p0_rdata`, `p1_rdata`  out  LINE_W  registered response line
- `p0_ready`, `p1_ready`  out  1  one-cycle completion pulse
- `p0_err`, `p1_err`  out  1  one-cycle timeout flag, coincident with ready
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  WDATA_W  memory write data
- `mem_read_req`, `mem_write_req`  out  1  one-cycle memory request pulses
- `mem_rdata`  in  LINE_W  memory read line
- `mem_ready`  in  1  memory completion pulse

## Operation
- Each port has a pending slot holding `pend`, `op` (rd/wr), `addr` and `wdata`.
- A slot captures when `read_req|write_req` is seen and its `pend` is 0. It sets `pend=1` and `op=write_req`.
- A pulse on a port whose `pend` is already 1 is dropped; the slot is unchanged.
- `read_req` and `write_req` together in one cycle is treated as a write.
- State machine, 2-bit encoding:
  - IDLE: if any `pend`, pick the grant, load `gnt`, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive `mem_addr`/`mem_wdata` from the `gnt` slot. Pulse `mem_read_req` or `mem_write_req` for exactly one cycle. Go to WAIT.
  - WAIT: on `mem_ready`, register `mem_rdata` into `p<gnt>_rdata` and go to RESP. Reads and writes both wait for `mem_ready`.
  - RESP: pulse `p<gnt>_ready`, clear `pend[gnt]`, set `last=gnt`, go to IDLE.
- Round-robin grant: if only one `pend` is set, that port wins. If both are set, the port `!last` wins. `last` resets to 1, so port 0 wins the first tie.
- A capture in the same cycle as that slot's RESP clear: the capture wins, so `pend` stays 1 with the new request.
- `mem_ready` outside WAIT is ignored.
- Slot contents are never modified while the slot is granted.
- `mem_addr`/`mem_wdata` are 0 outside ISSUE.
- `p*_rdata` holds its last value until the next response for that port.
- Write responses leave `p*_rdata` unchanged.

## Timing
- Reset values: state IDLE; `pend`=0; `last`=1; all `mem_*` outputs 0; `p*_ready`=0; `p*_err`=0; `p*_rdata`=0.
- `rst` mid-transaction drops all slots. A late `mem_ready` afterwards is ignored because the state is IDLE.
- Request pulse in cycle T: `mem_*_req` is high in cycle T+2. This holds when the arbiter is idle; no pending bypass.
- `mem_ready` in cycle M: `p*_ready` and the new `p*_rdata` are valid in cycle M+1.
- Back-to-back grants: after RESP in cycle R, the next ISSUE is in cycle R+2.
- Minimum period per transaction is 4 cycles plus memory latency.
- All outputs are registered or decoded from the state register only. There are no combinational paths from the `p*` inputs to the `mem_*` outputs.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears on entry to WAIT and increments each WAIT cycle without `mem_ready`.
  - When the count reaches `TIMEOUT_CYCLES`, the FSM goes to RESP with `p<gnt>_rdata`=0 and `p<gnt>_err`=1 for that cycle.
  - `mem_ready` in the same cycle as the limit wins: normal response, no error.
- `MEM_ARB_TIMEOUT_EN` undefined: WAIT lasts until `mem_ready`, no counter is synthesised, and `p*_err` is tied to 0.

## Test plan
- Port 0 read of 0x0000_1040, memory returns line 0xA5…A5 three cycles after `mem_read_req` -> `mem_addr`=0x0000_1040 at T+2; `p0_ready` pulse with `p0_rdata`=0xA5…A5 at M+1; `p1_ready` stays 0.
- Both ports pulse reads in the same cycle, first time after reset -> port 0 issued first. Port 1 is issued 2 cycles after port 0's RESP. A second simultaneous pair is then issued port 0 then port 1 again, because `last`=1 after that.
- Port 1 write of 0xDEAD_BEEF to 0x0000_2000 -> `mem_write_req` pulse with `mem_wdata`=0xDEAD_BEEF; `p1_ready` follows; `p1_rdata` unchanged.
- Second pulse on port 0 while its slot is pending -> dropped; exactly one `mem_read_req` and one `p0_ready`.
- `rst` asserted in WAIT, then `mem_ready` -> no `p*_ready`; state IDLE; no memory request until a new pulse.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `mem_ready` never asserts -> `p0_ready`=1, `p0_err`=1, `p0_rdata`=0 at the 8th WAIT cycle + 1. Without the macro -> FSM remains in WAIT.
